// File: rtl/fu_op_tracker.sv
// fu_op_tracker: fu_op class decode and per-slot in-flight class tracker.
// Define FU_OP_TRACKER_FPU_EN to decode FP load/store/arith codes 81-121.
module fu_op_tracker #(
  parameter int unsigned NR_SB_ENTRIES = 8,
  parameter int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES),
  parameter int unsigned OP_W          = 7,
  parameter int unsigned MAX_SPEC_BR   = 4,
  parameter int unsigned CNT_W         = $clog2(NR_SB_ENTRIES+1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [OP_W-1:0]          issue_op_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  input  logic                     retire_valid_i,
  input  logic [TRANS_ID_BITS-1:0] retire_trans_id_i,
  output logic                     class_valid_o,
  output logic [2:0]               class_o,
  output logic [TRANS_ID_BITS-1:0] class_trans_id_o,
  output logic                     illegal_o,
  output logic                     retire_err_o,
  output logic [8*CNT_W-1:0]       pending_cnt_o,
  output logic                     any_pending_o,
  output logic                     br_full_o
);

  localparam logic [2:0] C_OTHER  = 3'd0;
  localparam logic [2:0] C_BRANCH = 3'd1;
  localparam logic [2:0] C_JUMP   = 3'd2;
  localparam logic [2:0] C_LOAD   = 3'd3;
  localparam logic [2:0] C_STORE  = 3'd4;
  localparam logic [2:0] C_AMO    = 3'd5;
  localparam logic [2:0] C_MULDIV = 3'd6;
  localparam logic [2:0] C_FPU    = 3'd7;

  logic [NR_SB_ENTRIES-1:0] occ;
  logic [2:0]               cls [NR_SB_ENTRIES];
  logic [CNT_W-1:0]         cnt [8];
  logic [CNT_W-1:0]         cnt_nxt [8];

  int unsigned op_v;
  logic [2:0]  dec_cls;
  logic        dec_ill;
  logic        is_br;
  logic [CNT_W:0] br_cnt;
  logic        accept;
  logic        retire_hit;
  logic [2:0]  ret_cls;

  assign op_v = 32'(issue_op_i);

  always_comb begin
    dec_cls = C_OTHER;
    dec_ill = 1'b0;
    unique case (1'b1)
      op_v inside {[0:12], [20:34]}:     dec_cls = C_OTHER;
      op_v inside {[13:18]}:             dec_cls = C_BRANCH;
      op_v == 19:                        dec_cls = C_JUMP;
      op_v inside {35, 37, 38, 40, 41, 43, 45}:
                                         dec_cls = C_LOAD;
      op_v inside {36, 39, 42, 44}:      dec_cls = C_STORE;
      op_v inside {[46:67]}:             dec_cls = C_AMO;
      op_v inside {[68:80]}:             dec_cls = C_MULDIV;
`ifdef FU_OP_TRACKER_FPU_EN
      op_v inside {[81:84]}:             dec_cls = C_LOAD;
      op_v inside {[85:88]}:             dec_cls = C_STORE;
      op_v inside {[89:121]}:            dec_cls = C_FPU;
`endif
      default: begin
        dec_cls = C_OTHER;
        dec_ill = 1'b1;
      end
    endcase
  end

  assign is_br  = (dec_cls == C_BRANCH) || (dec_cls == C_JUMP);
  assign br_cnt = {1'b0, cnt[1]} + {1'b0, cnt[2]};
  assign br_full_o = (br_cnt == (CNT_W+1)'(MAX_SPEC_BR));

  assign issue_ready_o = !flush_i && !occ[issue_trans_id_i]
                         && !(is_br && br_full_o);
  assign accept     = issue_valid_i && issue_ready_o;
  assign retire_hit = retire_valid_i && occ[retire_trans_id_i] && !flush_i;
  assign ret_cls    = cls[retire_trans_id_i];

  // Issue and retire of the same class in one cycle cancel out.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      cnt_nxt[k] = cnt[k];
      if (accept && dec_cls == 3'(k))
        cnt_nxt[k] = cnt_nxt[k] + CNT_W'(1);
      if (retire_hit && ret_cls == 3'(k))
        cnt_nxt[k] = cnt_nxt[k] - CNT_W'(1);
    end
`ifndef FU_OP_TRACKER_FPU_EN
    cnt_nxt[7] = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ <= '0;
      for (int i = 0; i < NR_SB_ENTRIES; i++) cls[i] <= C_OTHER;
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else if (flush_i) begin
      occ <= '0;
      for (int k = 0; k < 8; k++) cnt[k] <= '0;
    end else begin
      if (retire_hit) occ[retire_trans_id_i] <= 1'b0;
      if (accept) begin
        occ[issue_trans_id_i] <= 1'b1;
        cls[issue_trans_id_i] <= dec_cls;
      end
      for (int k = 0; k < 8; k++) cnt[k] <= cnt_nxt[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      class_valid_o    <= 1'b0;
      class_o          <= C_OTHER;
      class_trans_id_o <= '0;
      illegal_o        <= 1'b0;
      retire_err_o     <= 1'b0;
    end else begin
      class_valid_o <= accept;
      if (accept) begin
        class_o          <= dec_cls;
        class_trans_id_o <= issue_trans_id_i;
        illegal_o        <= dec_ill;
      end
      retire_err_o <= retire_valid_i && !occ[retire_trans_id_i] && !flush_i;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_cnt
    assign pending_cnt_o[k*CNT_W +: CNT_W] = cnt[k];
  end

  assign any_pending_o = |occ;

endmodule

// File: doc/fu_op_tracker.md
# fu_op_tracker

Issue-side classifier and outstanding-operation tracker for the scoreboard. It generalises the combinational branch-opcode check to a full 8-class decode of `fu_op` codes and records the class of every in-flight `trans_id`. It keeps per-class pending counts and throttles issue when the speculative-branch limit is reached. It sits between the issue stage and the scoreboard, alongside the commit/flush path.

## Interface
Parameters:
- `NR_SB_ENTRIES`, 8: scoreboard depth; power of two, ≥2.
- `TRANS_ID_BITS`, `$clog2(NR_SB_ENTRIES)`: transaction-ID width.
- `OP_W`, 7: `fu_op` encoding width.
- `MAX_SPEC_BR`, 4: maximum in-flight BRANCH+JUMP ops; range 1..`NR_SB_ENTRIES`.
- `CNT_W`, `$clog2(NR_SB_ENTRIES+1)`: per-class counter width.

Ports:
- `clk_i`, in, 1: single clock; all state on rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: discard all in-flight state.
- `issue_valid_i`, in, 1: issue request.
- `issue_ready_o`, out, 1: issue accept (combinational).
- `issue_op_i`, in, `OP_W`: `fu_op` code.
- `issue_trans_id_i`, in, `TRANS_ID_BITS`: scoreboard slot.
- `retire_valid_i`, in, 1: commit/writeback of a slot.
- `retire_trans_id_i`, in, `TRANS_ID_BITS`: slot being retired.
- `class_valid_o`, out, 1: one-cycle pulse per accepted issue.
- `class_o`, out, 3: decoded class of that issue.
- `class_trans_id_o`, out, `TRANS_ID_BITS`: slot of that issue.
- `illegal_o`, out, 1: accepted op had an illegal code (qualified by `class_valid_o`).
- `retire_err_o`, out, 1: one-cycle pulse when a retire targets an empty slot.
- `pending_cnt_o`, out, 8*`CNT_W`: count for class k is at bits [k*`CNT_W` +: `CNT_W`].
- `any_pending_o`, out, 1: any slot occupied.
- `br_full_o`, out, 1: BRANCH+JUMP count equals `MAX_SPEC_BR`.

## Operation
Class decode of `issue_op_i` (decimal `fu_op` codes):
- 0 OTHER: 0–12, 21–34. Covers ALU, SLT and system/CSR ops.
- 1 BRANCH: 13–18 (LTS, LTU, GES, GEU, EQ, NE).
- 2 JUMP: 19 (JALR). Code 20 (BRANCH) decodes as OTHER.
- 3 LOAD: 35, 37, 38, 40, 41, 43, 45; 81–84.
- 4 STORE: 36, 39, 42, 44; 85–88.
- 5 AMO: 46–67.
- 6 MULDIV: 68–80.
- 7 FPU: 89–121.
- Codes ≥122 are illegal: class OTHER, `illegal_o`=1.

Issue handshake:
- `issue_ready_o` = `!flush_i` && `!occ[issue_trans_id_i]` && `!(class∈{BRANCH,JUMP} && br_full_o)`.
- Accept = `issue_valid_i && issue_ready_o`.
- On accept: set `occ[id]`, store the class in the `cls[id]` table, increment the count for that class.
- `issue_valid_i` may drop without being accepted; no stickiness.

Retire:
- If `occ[id]` is set: clear it and decrement the count for `cls[id]`.
- Else: no state change; `retire_err_o` pulses next cycle.

Simultaneous events:
- Issue and retire to different slots in the same cycle both take effect. If they hit the same class, the count is unchanged.
- No bypass: issue to a slot that is being retired in the same cycle is blocked, because ready is low while the slot is occupied.
- `flush_i` beats issue and retire. Next cycle, all `occ` bits and all counts are 0. A retire during flush raises no `retire_err_o`.

Counters never wrap. Overflow is impossible because of the occupancy gating; the bench asserts this.

## Timing
- Reset values: `occ`=0, all counts 0, `class_valid_o`=0, `class_o`=0, `class_trans_id_o`=0, `illegal_o`=0, `retire_err_o`=0, `any_pending_o`=0, `br_full_o`=0.
- `issue_ready_o` is 1 after reset while `flush_i`=0.
- Latency: the `class_*` and `illegal_o` outputs are registered and appear 1 cycle after accept.
- `pending_cnt_o`, `any_pending_o` and `br_full_o` are registered and reflect issue/retire 1 cycle later.
- `issue_ready_o` is combinational from inputs and registered state only; there is no path from `issue_valid_i`.
- Async reset assertion mid-operation clears all state immediately. Outputs return to reset values before the next edge.

## Configuration
- `FU_OP_TRACKER_FPU_EN` defined: codes 81–121 decode as listed above (FP loads → LOAD, FP stores → STORE, 89–121 → FPU).
- Undefined: codes 81–121 are illegal (class OTHER, `illegal_o`=1), but are still accepted and tracked. The FPU count at bits [7*`CNT_W` +: `CNT_W`] is constant 0.

## Test plan
- Reset, then issue op 17 (EQ) on id 3 → next cycle: `class_valid_o`=1, `class_o`=1, `class_trans_id_o`=3; BRANCH count=1; `any_pending_o`=1.
- Issue 4 branches (ops 13, 14, 15, 16) on ids 0–3 with `MAX_SPEC_BR`=4 → `br_full_o`=1. Then op 19 on id 4 sees `issue_ready_o`=0, while op 35 on id 4 is accepted with class 3.
- Issue on id 2, then in the same cycle retire id 2 and issue to id 2 → issue is blocked. The following cycle the issue is accepted and the count is unchanged net.
- Retire id 5 while it is empty → `retire_err_o` pulses once and all counts stay unchanged.
- Fill all 8 ids with mixed classes, then assert `flush_i` together with an issue and a retire → next cycle all counts are 0 and `any_pending_o`=0. No `class_valid_o` and no `retire_err_o`.
- Issue op 90 (FSUB) and op 125 → with the macro: class 7, `illegal_o`=0 for op 90; class 0, `illegal_o`=1 for op 125. Without the macro: both are class 0 with `illegal_o`=1.
